// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches regfile operands (with WB-to-ID bypass),
// decoded control and immediate; detects load-use hazards and handles flush/hold.
module id_ex_stage #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic               id_uses_rs1,
  input  logic               id_uses_rs2,
  input  logic [4:0]         id_rd,
  input  logic [XLEN-1:0]    id_rd1,
  input  logic [XLEN-1:0]    id_rd2,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               id_alu_src,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_mem_to_reg,
  input  logic               wb_we,
  input  logic [4:0]         wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  input  logic               flush,
  input  logic               ex_hold,
  output logic               stall_req,
  output logic               ex_valid,
  output logic [XLEN-1:0]    ex_pc,
  output logic [XLEN-1:0]    ex_rs1_val,
  output logic [XLEN-1:0]    ex_rs2_val,
  output logic [XLEN-1:0]    ex_imm,
  output logic [4:0]         ex_rs1,
  output logic [4:0]         ex_rs2,
  output logic [4:0]         ex_rd,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg
);

  // Flow control: an ID instruction is consumed on an edge where rst, flush,
  // ex_hold and stall_req are all low; ex_valid marks a real instruction in EX.
  logic               ex_valid_q,      ex_valid_d;
  logic [XLEN-1:0]    ex_pc_q,         ex_pc_d;
  logic [XLEN-1:0]    ex_rs1_val_q,    ex_rs1_val_d;
  logic [XLEN-1:0]    ex_rs2_val_q,    ex_rs2_val_d;
  logic [XLEN-1:0]    ex_imm_q,        ex_imm_d;
  logic [4:0]         ex_rs1_q,        ex_rs1_d;
  logic [4:0]         ex_rs2_q,        ex_rs2_d;
  logic [4:0]         ex_rd_q,         ex_rd_d;
  logic [ALUOP_W-1:0] ex_alu_op_q,     ex_alu_op_d;
  logic               ex_alu_src_q,    ex_alu_src_d;
  logic               ex_reg_write_q,  ex_reg_write_d;
  logic               ex_mem_read_q,   ex_mem_read_d;
  logic               ex_mem_write_q,  ex_mem_write_d;
  logic               ex_mem_to_reg_q, ex_mem_to_reg_d;

  logic [XLEN-1:0] rs1_byp;
  logic [XLEN-1:0] rs2_byp;
  logic            load_use;
  logic            wb_hit;

  // The regfile cannot show a same-cycle WB write, so bypass it here.
  always_comb begin
    wb_hit = wb_we && (wb_rd != 5'd0);
    if (wb_hit && (wb_rd == id_rs1))  rs1_byp = wb_data;
    else if (id_rs1 == 5'd0)          rs1_byp = '0;
    else                              rs1_byp = id_rd1;
    if (wb_hit && (wb_rd == id_rs2))  rs2_byp = wb_data;
    else if (id_rs2 == 5'd0)          rs2_byp = '0;
    else                              rs2_byp = id_rd2;
  end

  always_comb begin
    load_use = id_valid && ex_valid_q && ex_mem_read_q && (ex_rd_q != 5'd0) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd_q)) ||
                (id_uses_rs2 && (id_rs2 == ex_rd_q)));
    stall_req = load_use && !flush && !ex_hold;
  end

  always_comb begin
    ex_valid_d      = ex_valid_q;
    ex_pc_d         = ex_pc_q;
    ex_rs1_val_d    = ex_rs1_val_q;
    ex_rs2_val_d    = ex_rs2_val_q;
    ex_imm_d        = ex_imm_q;
    ex_rs1_d        = ex_rs1_q;
    ex_rs2_d        = ex_rs2_q;
    ex_rd_d         = ex_rd_q;
    ex_alu_op_d     = ex_alu_op_q;
    ex_alu_src_d    = ex_alu_src_q;
    ex_reg_write_d  = ex_reg_write_q;
    ex_mem_read_d   = ex_mem_read_q;
    ex_mem_write_d  = ex_mem_write_q;
    ex_mem_to_reg_d = ex_mem_to_reg_q;

    if (flush || (!ex_hold && stall_req)) begin
      // Kill or bubble: data fields are left as they are, control goes quiet.
      ex_valid_d      = 1'b0;
      ex_alu_op_d     = '0;
      ex_alu_src_d    = 1'b0;
      ex_reg_write_d  = 1'b0;
      ex_mem_read_d   = 1'b0;
      ex_mem_write_d  = 1'b0;
      ex_mem_to_reg_d = 1'b0;
    end else if (ex_hold) begin
      // A writer retiring while EX is frozen would otherwise leave stale operands.
      if (wb_hit && (wb_rd == ex_rs1_q)) ex_rs1_val_d = wb_data;
      if (wb_hit && (wb_rd == ex_rs2_q)) ex_rs2_val_d = wb_data;
    end else begin
      ex_valid_d      = id_valid;
      ex_pc_d         = id_pc;
      ex_rs1_val_d    = rs1_byp;
      ex_rs2_val_d    = rs2_byp;
      ex_imm_d        = id_imm;
      ex_rs1_d        = id_rs1;
      ex_rs2_d        = id_rs2;
      ex_rd_d         = id_rd;
      ex_alu_op_d     = id_valid ? id_alu_op : '0;
      ex_alu_src_d    = id_valid && id_alu_src;
      ex_reg_write_d  = id_valid && id_reg_write;
      ex_mem_read_d   = id_valid && id_mem_read;
      ex_mem_write_d  = id_valid && id_mem_write;
      ex_mem_to_reg_d = id_valid && id_mem_to_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q      <= 1'b0;
      ex_pc_q         <= '0;
      ex_rs1_val_q    <= '0;
      ex_rs2_val_q    <= '0;
      ex_imm_q        <= '0;
      ex_rs1_q        <= '0;
      ex_rs2_q        <= '0;
      ex_rd_q         <= '0;
      ex_alu_op_q     <= '0;
      ex_alu_src_q    <= 1'b0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      ex_mem_write_q  <= 1'b0;
      ex_mem_to_reg_q <= 1'b0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_pc_q         <= ex_pc_d;
      ex_rs1_val_q    <= ex_rs1_val_d;
      ex_rs2_val_q    <= ex_rs2_val_d;
      ex_imm_q        <= ex_imm_d;
      ex_rs1_q        <= ex_rs1_d;
      ex_rs2_q        <= ex_rs2_d;
      ex_rd_q         <= ex_rd_d;
      ex_alu_op_q     <= ex_alu_op_d;
      ex_alu_src_q    <= ex_alu_src_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
      ex_mem_write_q  <= ex_mem_write_d;
      ex_mem_to_reg_q <= ex_mem_to_reg_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_pc         = ex_pc_q;
  assign ex_rs1_val    = ex_rs1_val_q;
  assign ex_rs2_val    = ex_rs2_val_q;
  assign ex_imm        = ex_imm_q;
  assign ex_rs1        = ex_rs1_q;
  assign ex_rs2        = ex_rs2_q;
  assign ex_rd         = ex_rd_q;
  assign ex_alu_op     = ex_alu_op_q;
  assign ex_alu_src    = ex_alu_src_q;
  assign ex_reg_write  = ex_reg_write_q;
  assign ex_mem_read   = ex_mem_read_q;
  assign ex_mem_write  = ex_mem_write_q;
  assign ex_mem_to_reg = ex_mem_to_reg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: scenario tasks push expected EX bundles to a queue
// and pop/compare them one cycle later.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic [4:0]  rd;
    logic [31:0] rd1, rd2, imm;
    logic [3:0]  op;
    logic        src, rw, mr, mw, m2r;
  } id_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, v1, v2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic        src, rw, mr, mw, m2r;
  } out_t;

  localparam int OW = $bits(out_t);

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_uses_rs1, id_uses_rs2;
  logic [31:0] id_pc, id_rd1, id_rd2, id_imm, wb_data;
  logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic [3:0] id_alu_op;
  logic id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic wb_we, flush, ex_hold;
  logic stall_req, ex_valid;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [3:0] ex_alu_op;
  logic ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] msk_q[$];
  logic [OW-1:0] got, e, m, full_mask, ctrl_mask;
  int total = 0;
  int bad = 0;

  id_ex_stage #(.XLEN(32), .ALUOP_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .ex_hold(ex_hold), .stall_req(stall_req),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic drive_id(input id_t x);
    id_valid = x.valid; id_pc = x.pc; id_rs1 = x.rs1; id_rs2 = x.rs2;
    id_uses_rs1 = x.u1; id_uses_rs2 = x.u2; id_rd = x.rd;
    id_rd1 = x.rd1; id_rd2 = x.rd2; id_imm = x.imm; id_alu_op = x.op;
    id_alu_src = x.src; id_reg_write = x.rw; id_mem_read = x.mr;
    id_mem_write = x.mw; id_mem_to_reg = x.m2r;
  endtask

  task automatic drive_wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
    wb_we = we; wb_rd = rd; wb_data = d;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] byp(input logic [4:0] rs, input logic [31:0] rv,
                                      input logic we, input logic [4:0] wrd,
                                      input logic [31:0] wd);
    if (we && wrd != 5'd0 && wrd == rs) return wd;
    if (rs == 5'd0) return 32'h0;
    return rv;
  endfunction

  function automatic out_t exp_load(input id_t x, input logic [31:0] v1, input logic [31:0] v2);
    out_t o;
    o.valid = x.valid; o.pc = x.pc; o.v1 = v1; o.v2 = v2; o.imm = x.imm;
    o.rs1 = x.rs1; o.rs2 = x.rs2; o.rd = x.rd;
    o.op  = x.valid ? x.op : 4'h0;
    o.src = x.valid & x.src; o.rw = x.valid & x.rw; o.mr = x.valid & x.mr;
    o.mw  = x.valid & x.mw;  o.m2r = x.valid & x.m2r;
    return o;
  endfunction

  function automatic out_t get_out();
    out_t o;
    o.valid = ex_valid; o.pc = ex_pc; o.v1 = ex_rs1_val; o.v2 = ex_rs2_val; o.imm = ex_imm;
    o.rs1 = ex_rs1; o.rs2 = ex_rs2; o.rd = ex_rd; o.op = ex_alu_op;
    o.src = ex_alu_src; o.rw = ex_reg_write; o.mr = ex_mem_read;
    o.mw = ex_mem_write; o.m2r = ex_mem_to_reg;
    return o;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    id_t a;
    a = '{1'b1, 32'h100, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 32'h1111, 32'h2222, 32'h0,
          4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    @(negedge clk);
    rst = 1'b1; drive_id(a);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('0); msk_q.push_back(full_mask);
      @(posedge clk); #1;
      got = get_out(); e = exp_q.pop_front(); m = msk_q.pop_front();
      total++;
      if ((got & m) !== (e & m)) begin bad++; $display("FAIL reset_out got=%h exp=%h", got & m, e & m); end
    end
    total++;
    if (stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(exp_load(a, 32'h1111, 32'h2222)); msk_q.push_back(full_mask);
    @(posedge clk); #1;
    got = get_out(); e = exp_q.pop_front(); m = msk_q.pop_front();
    total++;
    if ((got & m) !== (e & m)) begin bad++; $display("FAIL reset_release got=%h exp=%h", got & m, e & m); end
  endtask

  task automatic test_bypass();
    id_t b;
    logic [31:0] v1 [3];
    logic [31:0] v2 [3];
    b = '{1'b1, 32'h104, 5'd5, 5'd6, 1'b1, 1'b1, 5'd8, 32'h11, 32'h22, 32'h4,
          4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    v1[0] = 32'hDEADBEEF; v2[0] = 32'h22;
    v1[1] = 32'h0;        v2[1] = 32'h22;
    v1[2] = 32'h11;       v2[2] = 32'h77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) drive_wb(1'b1, 5'd5, 32'hDEADBEEF);
      if (i == 1) begin b.rs1 = 5'd0; drive_wb(1'b1, 5'd0, 32'hDEADBEEF); end
      if (i == 2) begin b.rs1 = 5'd5; b.rs2 = 5'd9; b.rd2 = 32'h99; drive_wb(1'b1, 5'd9, 32'h77); end
      b.pc = 32'h104 + 32'(i * 4);
      drive_id(b);
      exp_q.push_back(exp_load(b, v1[i], v2[i])); msk_q.push_back(full_mask);
      @(posedge clk); #1;
      got = get_out(); e = exp_q.pop_front(); m = msk_q.pop_front();
      total++;
      if ((got & m) !== (e & m)) begin bad++; $display("FAIL bypass_%0d got=%h exp=%h", i, got & m, e & m); end
    end
    @(negedge clk);
    drive_wb(1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_load_use();
    id_t lw, add;
    lw  = '{1'b1, 32'h200, 5'd3, 5'd0, 1'b1, 1'b0, 5'd7, 32'h1000, 32'h0, 32'h10,
            4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    add = '{1'b1, 32'h204, 5'd7, 5'd2, 1'b1, 1'b1, 5'd1, 32'h70, 32'h20, 32'h0,
            4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    // three passes: real hazard, load to x0, consumer not reading rs1
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      lw.rd = (p == 1) ? 5'd0 : 5'd7;
      drive_id(lw);
      exp_q.push_back(exp_load(lw, 32'h1000, 32'h0)); msk_q.push_back(full_mask);
      @(posedge clk); #1;
      got = get_out(); e = exp_q.pop_front(); m = msk_q.pop_front();
      total++;
      if ((got & m) !== (e & m)) begin bad++; $display("FAIL lu_load_%0d got=%h exp=%h", p, got & m, e & m); end
      @(negedge clk);
      add.rs1 = (p == 1) ? 5'd0 : 5'd7;
      add.u1  = (p == 2) ? 1'b0 : 1'b1;
      drive_id(add);
      #1;
      total++;
      if (stall_req !== (p == 0)) begin bad++; $display("FAIL lu_stall_%0d got=%b exp=%b", p, stall_req, p == 0); end
      if (p == 0) begin
        exp_q.push_back('0); msk_q.push_back(ctrl_mask);
        @(posedge clk); #1;
        got = get_out(); e = exp_q.pop_front(); m = msk_q.pop_front();
        total++;
        if ((got & m) !== (e & m)) begin bad++; $display("FAIL lu_bubble got=%h exp=%h", got & m, e & m); end
        @(negedge clk); #1;
        total++;
        if (stall_req !== 1'b0) begin bad++; $display("FAIL lu_stall_after got=%b exp=0", stall_req); end
      end
      exp_q.push_back(exp_load(add, (add.rs1 == 5'd0) ? 32'h0 : 32'h70, 32'h20));
      msk_q.push_back(full_mask);
      @(posedge clk); #1;
      got = get_out(); e = exp_q.pop_front(); m = msk_q.pop_front();
      total++;
      if ((got & m) !== (e & m)) begin bad++; $display("FAIL lu_consumer_%0d got=%h exp=%h", p, got & m, e & m); end
    end
  endtask

  task automatic test_hold();
    id_t h, use9;
    out_t held;
    h    = '{1'b1, 32'h300, 5'd4, 5'd9, 1'b1, 1'b0, 5'd9, 32'h44, 32'h99, 32'h8,
             4'h3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    use9 = '{1'b1, 32'h304, 5'd9, 5'd1, 1'b1, 1'b1, 5'd2, 32'h5, 32'h6, 32'h0,
             4'h5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    @(negedge clk);
    drive_id(h);
    held = exp_load(h, 32'h44, 32'h99);
    exp_q.push_back(held); msk_q.push_back(full_mask);
    @(posedge clk); #1;
    got = get_out(); e = exp_q.pop_front(); m = msk_q.pop_front();
    total++;
    if ((got & m) !== (e & m)) begin bad++; $display("FAIL hold_setup got=%h exp=%h", got & m, e & m); end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      ex_hold = 1'b1;
      drive_id(use9);
      if (c == 2) drive_wb(1'b1, 5'd9, 32'h42);
      else        drive_wb(1'b0, 5'd9, 32'hBAD0BAD0);
      #1;
      total++;
      if (stall_req !== 1'b0) begin bad++; $display("FAIL hold_stall_%0d got=%b exp=0", c, stall_req); end
      if (c == 2) held.v2 = 32'h42;
      exp_q.push_back(held); msk_q.push_back(full_mask);
      @(posedge clk); #1;
      got = get_out(); e = exp_q.pop_front(); m = msk_q.pop_front();
      total++;
      if ((got & m) !== (e & m)) begin bad++; $display("FAIL hold_cycle_%0d got=%h exp=%h", c, got & m, e & m); end
    end
    @(negedge clk);
    ex_hold = 1'b0; drive_wb(1'b0, 5'd0, 32'h0);
    #1;
    total++;
    if (stall_req !== 1'b1) begin bad++; $display("FAIL hold_release_stall got=%b exp=1", stall_req); end
    exp_q.push_back('0); msk_q.push_back(ctrl_mask);
    @(posedge clk); #1;
    got = get_out(); e = exp_q.pop_front(); m = msk_q.pop_front();
    total++;
    if ((got & m) !== (e & m)) begin bad++; $display("FAIL hold_release_bubble got=%h exp=%h", got & m, e & m); end
  endtask

  task automatic test_flush();
    id_t lw, add;
    lw  = '{1'b1, 32'h400, 5'd3, 5'd0, 1'b1, 1'b0, 5'd7, 32'h1, 32'h0, 32'h0,
            4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    add = '{1'b1, 32'h404, 5'd7, 5'd7, 1'b1, 1'b1, 5'd1, 32'h2, 32'h3, 32'h0,
            4'h6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    @(negedge clk);
    drive_id(lw);
    @(posedge clk);
    @(negedge clk);
    drive_id(add); flush = 1'b1; ex_hold = 1'b1;
    #1;
    total++;
    if (stall_req !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", stall_req); end
    exp_q.push_back('0); msk_q.push_back(ctrl_mask);
    @(posedge clk); #1;
    got = get_out(); e = exp_q.pop_front(); m = msk_q.pop_front();
    total++;
    if ((got & m) !== (e & m)) begin bad++; $display("FAIL flush_kill got=%h exp=%h", got & m, e & m); end
    @(negedge clk);
    flush = 1'b0; ex_hold = 1'b0;
  endtask

  task automatic test_mid_reset();
    id_t a;
    a = '{1'b1, 32'h500, 5'd10, 5'd11, 1'b1, 1'b1, 5'd12, 32'hA, 32'hB, 32'hC,
          4'h7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    @(negedge clk);
    drive_id(a);
    @(posedge clk);
    @(negedge clk);
    ex_hold = 1'b1; rst = 1'b1;
    exp_q.push_back('0); msk_q.push_back(full_mask);
    @(posedge clk); #1;
    got = get_out(); e = exp_q.pop_front(); m = msk_q.pop_front();
    total++;
    if ((got & m) !== (e & m)) begin bad++; $display("FAIL mid_reset got=%h exp=%h", got & m, e & m); end
    @(negedge clk);
    rst = 1'b0; ex_hold = 1'b0;
  endtask

  task automatic test_back_to_back();
    id_t x;
    logic we;
    logic [4:0] wrd;
    logic [31:0] wd;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      x.valid = ($urandom_range(0, 3) != 0);
      x.pc = 32'h600 + 32'(i * 4);
      x.rs1 = 5'($urandom_range(0, 31)); x.rs2 = 5'($urandom_range(0, 31));
      x.u1 = 1'($urandom_range(0, 1)); x.u2 = 1'($urandom_range(0, 1));
      x.rd = 5'($urandom_range(0, 31));
      x.rd1 = $urandom; x.rd2 = $urandom; x.imm = $urandom;
      x.op = 4'($urandom_range(0, 15));
      x.src = 1'($urandom_range(0, 1)); x.rw = 1'($urandom_range(0, 1));
      x.mr = 1'b0; x.mw = 1'($urandom_range(0, 1)); x.m2r = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       wrd = x.rs1;
        1:       wrd = x.rs2;
        default: wrd = 5'($urandom_range(0, 31));
      endcase
      wd = $urandom;
      drive_id(x); drive_wb(we, wrd, wd);
      exp_q.push_back(exp_load(x, byp(x.rs1, x.rd1, we, wrd, wd), byp(x.rs2, x.rd2, we, wrd, wd)));
      msk_q.push_back(full_mask);
      @(posedge clk); #1;
      got = get_out(); e = exp_q.pop_front(); m = msk_q.pop_front();
      total++;
      if ((got & m) !== (e & m)) begin bad++; $display("FAIL b2b_%0d got=%h exp=%h", i, got & m, e & m); end
    end
    @(negedge clk);
    drive_wb(1'b0, 5'd0, 32'h0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    out_t cm;
    cm = '0;
    cm.valid = 1'b1; cm.op = 4'hF; cm.src = 1'b1; cm.rw = 1'b1;
    cm.mr = 1'b1; cm.mw = 1'b1; cm.m2r = 1'b1;
    ctrl_mask = cm;
    full_mask = '1;
    rst = 1'b1; flush = 1'b0; ex_hold = 1'b0;
    drive_id('0); drive_wb(1'b0, 5'd0, 32'h0);

    test_reset();
    test_bypass();
    test_load_use();
    test_hold();
    test_flush();
    test_mid_reset();
    test_back_to_back();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage core.
- Sits directly downstream of the register file. It latches the rs1/rs2 read data together with the decoded control and immediate fields, and hands them to EX.
- The register file writes on the clock edge and reads combinationally, so a same-cycle WB write is not visible at its read ports. This block therefore supplies the WB-to-ID bypass.
- It also detects load-use hazards, inserts bubbles, and handles flush and hold from downstream.

Parameters:
XLEN, 32, datapath width (operands, immediate, PC, WB data)
ALUOP_W, 4, width of the ALU operation code

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of ID instruction
id_rs1  in  5  rs1 address (same value driven to regfile ra1)
id_rs2  in  5  rs2 address (same value driven to regfile ra2)
id_uses_rs1  in  1  instruction reads rs1
id_uses_rs2  in  1  instruction reads rs2
id_rd  in  5  destination register
id_rd1  in  XLEN  regfile rd1
id_rd2  in  XLEN  regfile rd2
id_imm  in  XLEN  sign-extended immediate
id_alu_op  in  ALUOP_W  ALU operation
id_alu_src  in  1  1 = operand B is immediate
id_reg_write  in  1  writes rd
id_mem_read  in  1  load
id_mem_write  in  1  store
id_mem_to_reg  in  1  WB selects memory data
wb_we  in  1  WB stage writing regfile this cycle
wb_rd  in  5  WB destination
wb_data  in  XLEN  WB write data
flush  in  1  branch/jump redirect; kill ID instruction
ex_hold  in  1  EX cannot accept; freeze register
stall_req  out  1  combinational; freeze PC and IF/ID this cycle
ex_valid  out  1  EX holds a real instruction
ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  XLEN each  latched values
ex_rs1, ex_rs2, ex_rd  out  5 each  latched addresses (for EX forwarding unit)
ex_alu_op  out  ALUOP_W  latched control
ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  latched control

Behaviour:
- Reset: all ex_* outputs are 0, including ex_valid=0. stall_req is 0 while ex_valid=0.
- Bypass, applied separately to each operand:
  - If wb_we=1, wb_rd!=0 and wb_rd==id_rsN, the operand is wb_data.
  - Else if id_rsN==0, the operand is 0.
  - Otherwise the operand is id_rdN.
- Load-use hazard: stall_req = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - stall_req is forced to 0 when flush=1 or ex_hold=1.
- Per-edge update priority (highest first):
  1. rst: clear all outputs.
  2. flush: ex_valid<=0 and all ex_* control bits<=0. Data fields are don't-care.
  3. ex_hold: retain all fields, except for the held-operand refresh:
     - If wb_we=1, wb_rd!=0 and wb_rd==ex_rsN, then ex_rsN_val<=wb_data.
     - This prevents stale operands when a writer retires during the hold.
  4. stall_req: insert a bubble. ex_valid<=0 and control bits<=0. ID is not consumed; upstream re-presents it next cycle.
  5. Otherwise load the ID fields and bypassed operands. ex_valid<=id_valid. If id_valid=0, control bits<=0.
- Latency: one cycle from ID to EX.
- A load-use stall lasts exactly one cycle. After the bubble, ex_mem_read=0, so the consumer advances; the EX forwarding unit takes the load result from MEM/WB.
- flush takes precedence over a same-cycle stall_req and ex_hold.
- Control bits are never set while ex_valid=0.

Test Plan:
- Reset: hold rst=1 for 2 cycles with id_valid=1 -> all ex_* are 0 and stall_req=0. Release; next edge loads ID.
- WB bypass: id_rs1=5, id_rd1=0x11, wb_we=1, wb_rd=5, wb_data=0xDEADBEEF -> next cycle ex_rs1_val=0xDEADBEEF.
  - Same stimulus with wb_rd=0 and id_rs1=0 -> ex_rs1_val=0.
- Load-use: EX holds lw x7 (ex_mem_read=1, ex_rd=7); ID is add x1,x7,x2 with id_uses_rs1=1 -> stall_req=1 and next ex_valid=0.
  - The cycle after, the add loads.
  - Same case with ex_rd=0, or with id_uses_rs1=0 -> stall_req=0.
- Hold with refresh: ex_hold=1 for 3 cycles with ex_rs2=9; in cycle 2 drive wb_we=1, wb_rd=9, wb_data=0x42 -> ex_rs2_val=0x42. All other fields are unchanged.
- Flush priority: flush=1 with a concurrent load-use hazard and ex_hold=1 -> stall_req=0; next ex_valid=0, ex_reg_write=0 and ex_mem_write=0.
- Mid-operation reset: rst=1 during ex_hold with ex_valid=1 -> next edge all outputs are 0.
